// File: rtl/line_buffer_3rows.sv
// line_buffer_3rows: two-row line buffer that turns a raster pixel stream into
// vertically aligned three-pixel columns (rows r-2, r-1, r) for a 3x3 window.
module line_buffer_3rows #(
    parameter int unsigned COLS = 5,
    parameter int unsigned ROWS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic [7:0] S1_o,
    output logic [7:0] S2_o,
    output logic [7:0] S3_o,
    output logic       valid_o,
    output logic       frame_done_o
);

    localparam int unsigned PIX_W = 8;
    localparam int unsigned CNT_W = 10;
    localparam int unsigned IDX_W = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COLS - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROWS - 1);

    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [PIX_W-1:0] line0_q [COLS];
    logic [PIX_W-1:0] line0_d [COLS];
    logic [PIX_W-1:0] line1_q [COLS];
    logic [PIX_W-1:0] line1_d [COLS];
    logic [PIX_W-1:0] s1_q, s1_d;
    logic [PIX_W-1:0] s2_q, s2_d;
    logic [PIX_W-1:0] s3_q, s3_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] idx;
    logic             last_col;
    logic             last_row;

    // Column counter never exceeds COLS-1, so truncating it to the memory index is safe.
    always_comb begin
        idx      = IDX_W'(col_q);
        last_col = (col_q == COL_LAST);
        last_row = (row_q == ROW_LAST);
    end

    // Next state: shift the column through both line memories and advance the raster position.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        line0_d = line0_q;
        line1_d = line1_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        s3_d    = s3_q;
        valid_d = 1'b0;
        done_d  = 1'b0;

        if (valid_i) begin
            s3_d         = data_i;
            s2_d         = line1_q[idx];
            s1_d         = line0_q[idx];
            line0_d[idx] = line1_q[idx];
            line1_d[idx] = data_i;
            valid_d      = (row_q >= CNT_W'(2));
            done_d       = last_row && last_col;

            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset also clears the line memories.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            line0_q <= '{default: '0};
            line1_q <= '{default: '0};
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            line0_q <= line0_d;
            line1_q <= line1_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign S1_o         = s1_q;
    assign S2_o         = s2_q;
    assign S3_o         = s3_q;
    assign valid_o      = valid_q;
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_line_buffer_3rows.sv
// Directed bench for line_buffer_3rows: 5x5 instance driven from a vector table,
// plus an 8x3 instance exercised by a hand-written sequence.
module tb_line_buffer_3rows;

    typedef struct {
        logic       vin;
        logic [7:0] din;
        logic       ev;
        logic       ed;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] e3;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] data_i;
    logic       valid_i;
    logic [7:0] S1_o, S2_o, S3_o;
    logic       valid_o, frame_done_o;

    logic [7:0] ns_data;
    logic       ns_valid;
    logic [7:0] ns_s1, ns_s2, ns_s3;
    logic       ns_valid_o, ns_done_o;

    vec_t        vecs[$];
    logic [7:0]  hist[$];
    logic [23:0] cols_seen[$];
    logic [23:0] cols_a[$];
    logic [7:0]  last1, last2, last3;
    int          errors;
    int          checks;
    int          vcount;
    int          dcount;

    line_buffer_3rows #(.COLS(5), .ROWS(5)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .S1_o         (S1_o),
        .S2_o         (S2_o),
        .S3_o         (S3_o),
        .valid_o      (valid_o),
        .frame_done_o (frame_done_o)
    );

    line_buffer_3rows #(.COLS(8), .ROWS(3)) u_ns (
        .clk          (clk),
        .rst          (rst),
        .data_i       (ns_data),
        .valid_i      (ns_valid),
        .S1_o         (ns_s1),
        .S2_o         (ns_s2),
        .S3_o         (ns_s3),
        .valid_o      (ns_valid_o),
        .frame_done_o (ns_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_col(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got S1/S2/S3=%0d/%0d/%0d expected %0d/%0d/%0d", name,
                     act[23:16], act[15:8], act[7:0], exp[23:16], exp[15:8], exp[7:0]);
        end
    endtask

    // Reference: S2 is the pixel accepted one row (5 pixels) earlier, S1 two rows earlier.
    task automatic add_pix(input int base, input int r, input int c);
        vec_t v;
        int   n;
        n     = hist.size();
        v.vin = 1'b1;
        v.din = 8'(base + 10 * r + c);
        v.ev  = (r >= 2);
        v.ed  = (r == 4) && (c == 4);
        v.e1  = (n >= 10) ? hist[n - 10] : 8'd0;
        v.e2  = (n >= 5) ? hist[n - 5] : 8'd0;
        v.e3  = v.din;
        hist.push_back(v.din);
        last1 = v.e1;
        last2 = v.e2;
        last3 = v.e3;
        vecs.push_back(v);
    endtask

    task automatic add_idle(input int cycles);
        vec_t v;
        for (int i = 0; i < cycles; i++) begin
            v.vin = 1'b0;
            v.din = 8'hA5;
            v.ev  = 1'b0;
            v.ed  = 1'b0;
            v.e1  = last1;
            v.e2  = last2;
            v.e3  = last3;
            vecs.push_back(v);
        end
    endtask

    task automatic add_frame(input int base);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                add_pix(base, r, c);
    endtask

    task automatic apply_vecs(input string tag);
        vcount = 0;
        dcount = 0;
        cols_seen.delete();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            data_i  = vecs[i].din;
            valid_i = vecs[i].vin;
            @(posedge clk);
            #1;
            chk({tag, " valid_o"}, int'(valid_o), int'(vecs[i].ev));
            chk({tag, " frame_done_o"}, int'(frame_done_o), int'(vecs[i].ed));
            chk_col({tag, " column"}, {S1_o, S2_o, S3_o}, {vecs[i].e1, vecs[i].e2, vecs[i].e3});
            if (valid_o) begin
                vcount++;
                cols_seen.push_back({S1_o, S2_o, S3_o});
            end
            if (frame_done_o) dcount++;
        end
        valid_i = 1'b0;
        vecs.delete();
    endtask

    initial begin
        int ns_vc;
        int ns_dc;
        errors   = 0;
        checks   = 0;
        last1    = 8'd0;
        last2    = 8'd0;
        last3    = 8'd0;
        rst      = 1'b1;
        data_i   = 8'd0;
        valid_i  = 1'b0;
        ns_data  = 8'd0;
        ns_valid = 1'b0;

        // Reset state
        #12;
        chk_col("reset column", {S1_o, S2_o, S3_o}, 24'd0);
        chk("reset valid_o", int'(valid_o), 0);
        chk("reset frame_done_o", int'(frame_done_o), 0);
        @(negedge clk);
        rst = 1'b0;

        // Continuous frame, pixel = 10*r + c
        add_frame(0);
        apply_vecs("contig");
        chk("contig valid count", vcount, 15);
        chk("contig done count", dcount, 1);
        chk_col("contig first col", cols_seen[0], {8'd0, 8'd10, 8'd20});
        chk_col("contig col (3,2)", cols_seen[7], {8'd12, 8'd22, 8'd32});
        chk_col("contig last col", cols_seen[14], {8'd24, 8'd34, 8'd44});
        cols_a = cols_seen;

        // Same frame with alternating idle cycles and a 7-cycle gap before (2,4)
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                if (r == 2 && c == 4) add_idle(7);
                add_pix(0, r, c);
                add_idle(1);
            end
        apply_vecs("gappy");
        chk("gappy valid count", vcount, 15);
        chk("gappy done count", dcount, 1);
        for (int i = 0; i < 15; i++)
            chk_col("gappy same column", cols_seen[i], cols_a[i]);

        // Back-to-back frames
        add_frame(0);
        add_frame(100);
        apply_vecs("b2b");
        chk("b2b valid count", vcount, 30);
        chk("b2b done count", dcount, 2);
        chk_col("b2b frame2 first col", cols_seen[15], {8'd100, 8'd110, 8'd120});
        chk_col("b2b frame2 last col", cols_seen[29], {8'd124, 8'd134, 8'd144});

        // Partial frame up to (3,1), then asynchronous reset between edges
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++)
                if (r < 3 || c <= 1) add_pix(0, r, c);
        apply_vecs("prerst");
        chk("prerst S3 nonzero", int'(S3_o), 31);
        #2;
        rst = 1'b1;
        #1;
        chk_col("async reset column", {S1_o, S2_o, S3_o}, 24'd0);
        chk("async reset valid_o", int'(valid_o), 0);
        chk("async reset frame_done_o", int'(frame_done_o), 0);
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        last1 = 8'd0;
        last2 = 8'd0;
        last3 = 8'd0;

        add_frame(200);
        apply_vecs("postrst");
        chk("postrst valid count", vcount, 15);
        chk("postrst done count", dcount, 1);
        chk_col("postrst first col", cols_seen[0], {8'd200, 8'd210, 8'd220});

        // Non-square 8x3 frame on the second instance
        ns_vc = 0;
        ns_dc = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                ns_data  = 8'(10 * r + c);
                ns_valid = 1'b1;
                @(posedge clk);
                #1;
                chk("ns valid_o", int'(ns_valid_o), int'(r == 2));
                chk("ns frame_done_o", int'(ns_done_o), int'(r == 2 && c == 7));
                if (ns_valid_o) begin
                    ns_vc++;
                    chk_col("ns column", {ns_s1, ns_s2, ns_s3},
                            {8'(c), 8'(10 + c), 8'(20 + c)});
                end
                if (ns_done_o) begin
                    ns_dc++;
                    chk("ns S3 at done", int'(ns_s3), 27);
                end
            end
        ns_valid = 1'b0;
        chk("ns valid count", ns_vc, 8);
        chk("ns done count", ns_dc, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_buffer_3rows.md
# line_buffer_3rows

Upstream stage of the 3x3 window buffer. It accepts one raster-order 8-bit pixel stream and stores the two previous image rows in two COLS-deep line memories. For every pixel it emits a registered, vertically aligned column of three pixels (rows r-2, r-1, r). The three outputs drive the window buffer's S1_i/S2_i/S3_i inputs, and valid_o drives its count_en.

## Interface
Parameters:
- COLS, 5, pixels per row; legal range 3..1024
- ROWS, 5, rows per frame; legal range 3..1024

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- data_i  in  8  input pixel, raster order, left to right then top to bottom
- valid_i  in  1  data_i qualifier; one pixel is accepted per cycle in which valid_i=1
- S1_o  out  8  pixel at (r-2, c)
- S2_o  out  8  pixel at (r-1, c)
- S3_o  out  8  pixel at (r, c), i.e. the accepted pixel
- valid_o  out  1  S1_o..S3_o hold a complete column
- frame_done_o  out  1  one-cycle pulse with the column of the last pixel of a frame

## Operation
- State:
  - col counter, 10 bits, 0..COLS-1
  - row counter, 10 bits, 0..ROWS-1
  - line0[COLS], holds row r-2
  - line1[COLS], holds row r-1
  - output registers
- On each accepted pixel p at position (row, col):
  - S3_o <= p
  - S2_o <= line1[col]
  - S1_o <= line0[col]
  - line0[col] <= line1[col]; reads of both memories use their pre-edge values
  - line1[col] <= p
  - valid_o <= (row >= 2)
  - frame_done_o <= (row == ROWS-1 && col == COLS-1)
- Counter update on each accepted pixel:
  - col increments.
  - When col == COLS-1, col wraps to 0 and row increments.
  - When row == ROWS-1 and col == COLS-1, both counters wrap to 0. The next accepted pixel is (0,0) of a new frame.
- valid_i=0 cycle:
  - Counters, memories and S1_o..S3_o hold.
  - valid_o <= 0 and frame_done_o <= 0.
- Line memories are not cleared between frames. Stale data from the previous frame appears only while row < 2, and valid_o masks it there.
- Comparisons use unsigned 10-bit arithmetic. COLS-1 and ROWS-1 are compared as 10-bit constants.

## Timing
- Reset values: S1_o = S2_o = S3_o = 0, valid_o = 0, frame_done_o = 0, col = 0, row = 0.
  - Reset also clears both line memories to 0.
  - Reset takes effect immediately, without waiting for a clock edge.
- Latency: exactly 1 cycle from the accepting edge to the outputs. No combinational path from inputs to outputs.
- Throughput: 1 pixel per cycle sustained. valid_i may drop for any number of cycles at any pixel position.
- Per frame:
  - valid_o is asserted exactly (ROWS-2)*COLS times.
  - The first assertion follows pixel (2,0).
  - The last assertion follows pixel (ROWS-1, COLS-1), together with frame_done_o.
- Frames may run back to back with no idle cycle. Pixel (0,0) of frame N+1 may be accepted on the cycle right after pixel (ROWS-1, COLS-1) of frame N. Its cycle shows valid_o=0 and frame_done_o=0.
- Reset mid-frame: counters return to 0 and the next accepted pixel is treated as (0,0). The first valid_o after release follows the third new row.
- No backpressure input. The downstream window buffer must consume every column in which valid_o=1.

## Test plan
- Reset check: assert rst asynchronously between clock edges with outputs non-zero.
  - Required: all outputs read 0 before the next clock edge.
  - Required: the first pixel after release is treated as (0,0).
- Continuous 5x5 frame, pixel value = 10*r + c:
  - First valid_o follows pixel (2,0), with S1=0, S2=10, S3=20.
  - Column after pixel (3,2): S1=12, S2=22, S3=32.
  - Last column: S1=24, S2=34, S3=44 with frame_done_o=1.
  - valid_o count = 15.
- Same 5x5 frame with valid_i toggling 1,0,1,0 and a 7-cycle gap at pixel (2,4):
  - Required: identical sequence of valid columns.
  - Required: outputs hold during gaps.
  - Required: valid_o=0 on every gap cycle.
- Back-to-back 5x5 frames; frame 2 pixels = 100 + 10*r + c, no idle cycle between frames:
  - No valid_o during frame 2 rows 0-1.
  - Frame 2's first valid column: S1=100, S2=110, S3=120.
  - Exactly one frame_done_o pulse per frame.
- Reset mid-frame at pixel (3,1), then a full 5x5 frame with values 200 + 10*r + c:
  - First valid column: S1=200, S2=210, S3=220.
  - valid_o count = 15.
- Non-square frame, COLS=8, ROWS=3:
  - valid_o is asserted for exactly 8 columns.
  - frame_done_o coincides with S3=27 (10*2 + 7).
